// File: rtl/bcd_stopwatch_if.sv
// Control and display bundle of the MM:SS stopwatch.
// The master side drives tick/start_stop/clear and observes the digits.
// The slave side is the stopwatch itself.
interface bcd_stopwatch_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       running;
    logic [3:0] sec_u;
    logic [3:0] sec_t;
    logic [3:0] min_u;
    logic [3:0] min_t;
    logic       max_reached;
    logic       wrap_pulse;

    modport master (
        output tick_in, start_stop, clear,
        input  running, sec_u, sec_t, min_u, min_t, max_reached, wrap_pulse
    );

    modport slave (
        input  tick_in, start_stop, clear,
        output running, sec_u, sec_t, min_u, min_t, max_reached, wrap_pulse
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch counting rising edges of a divided tick as four BCD digits.
// IDLE/RUN/PAUSE/HOLD control, clear has top priority, all outputs registered.
// STOP_AT_MAX selects saturation (HOLD at max) or wrap to 00:00 with a pulse.
module bcd_stopwatch #(
    parameter int STOP_AT_MAX = 1,
    parameter int SEC_T_MAX   = 5,
    parameter int MIN_T_MAX   = 5
) (
    input  logic              clk,
    input  logic              rst,
    bcd_stopwatch_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0]  SEC_T_LIM = 4'(SEC_T_MAX);
    localparam logic [3:0]  MIN_T_LIM = 4'(MIN_T_MAX);
    localparam logic [15:0] MAX_VAL   = {MIN_T_LIM, 4'd9, SEC_T_LIM, 4'd9};

    // Digits packed as {min_t, min_u, sec_t, sec_u}.
    // Comparisons use >= so a corrupted digit is pulled back into range.
    function automatic logic [15:0] bcd_inc(input logic [15:0] cur);
        logic [3:0] su;
        logic [3:0] st;
        logic [3:0] mu;
        logic [3:0] mt;
        {mt, mu, st, su} = cur;
        if (su >= 4'd9) begin
            su = 4'd0;
            if (st >= SEC_T_LIM) begin
                st = 4'd0;
                if (mu >= 4'd9) begin
                    mu = 4'd0;
                    if (mt >= MIN_T_LIM) begin
                        mt = 4'd0;
                    end else begin
                        mt = mt + 4'd1;
                    end
                end else begin
                    mu = mu + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            su = su + 4'd1;
        end
        return {mt, mu, st, su};
    endfunction

    state_t      state_q,  state_d;
    logic        tick_q,   tick_d;
    logic [15:0] digits_q, digits_d;
    logic        running_q, running_d;
    logic        max_q,    max_d;
    logic        wrap_q,   wrap_d;

    logic        tick_rise_s;
    logic        at_max_s;

    assign tick_rise_s = bus.tick_in & ~tick_q;
    assign at_max_s    = (digits_q == MAX_VAL);

    // Next-state, digit and output decode for the stopwatch FSM.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        tick_d   = bus.tick_in;

        if (bus.clear) begin
            state_d  = ST_IDLE;
            digits_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    digits_d = 16'h0000;
                    if (bus.start_stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_rise_s && at_max_s) begin
                        if (STOP_AT_MAX != 0) begin
                            // Saturate: digits stay at max, HOLD wins over start_stop.
                            state_d = ST_HOLD;
                        end else begin
                            digits_d = 16'h0000;
                            wrap_d   = 1'b1;
                            if (bus.start_stop) begin
                                state_d = ST_PAUSE;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        if (tick_rise_s) begin
                            digits_d = bcd_inc(digits_q);
                        end else begin
                            digits_d = digits_q;
                        end
                        if (bus.start_stop) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d  = ST_IDLE;
                    digits_d = 16'h0000;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        max_d     = (state_d == ST_HOLD);
    end

    // State and registered outputs; async reset drops any pending tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= 1'b0;
            digits_q  <= 16'h0000;
            running_q <= 1'b0;
            max_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            digits_q  <= digits_d;
            running_q <= running_d;
            max_q     <= max_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.sec_u       = digits_q[3:0];
    assign bus.sec_t       = digits_q[7:4];
    assign bus.min_u       = digits_q[11:8];
    assign bus.min_t       = digits_q[15:12];
    assign bus.running     = running_q;
    assign bus.max_reached = max_q;
    assign bus.wrap_pulse  = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: one saturating and one wrapping instance
// driven with identical stimulus, compared against hand-computed values.
module tb_bcd_stopwatch;

    logic clk;
    logic rst;
    logic tick;
    logic ss;
    logic clr;

    int n_cmp;
    int n_bad;

    bcd_stopwatch_if bus_a ();
    bcd_stopwatch_if bus_b ();

    assign bus_a.tick_in    = tick;
    assign bus_a.start_stop = ss;
    assign bus_a.clear      = clr;
    assign bus_b.tick_in    = tick;
    assign bus_b.start_stop = ss;
    assign bus_b.clear      = clr;

    bcd_stopwatch #(.STOP_AT_MAX(1), .SEC_T_MAX(5), .MIN_T_MAX(5)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    bcd_stopwatch #(.STOP_AT_MAX(0), .SEC_T_MAX(5), .MIN_T_MAX(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        ss;
        logic        clr;
        logic        run;
        logic [15:0] digits;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [15:0] dig_a();
        return {bus_a.min_t, bus_a.min_u, bus_a.sec_t, bus_a.sec_u};
    endfunction

    function automatic logic [15:0] dig_b();
        return {bus_b.min_t, bus_b.min_u, bus_b.sec_t, bus_b.sec_u};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One tick: high for 3 cycles, low for 1; starts and ends on a negedge.
    task automatic do_tick();
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic pulse_ss();
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tick  = 1'b0;
        ss    = 1'b0;
        clr   = 1'b0;
        rst   = 1'b1;

        //           tick  ss    clr   run   digits
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0002};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0003};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

        repeat (3) @(negedge clk);
        check("reset_run",  32'(bus_a.running), 32'd0);
        check("reset_dig",  32'(dig_a()), 32'h0000);
        check("reset_max",  32'(bus_a.max_reached), 32'd0);
        check("reset_wrap", 32'(bus_b.wrap_pulse), 32'd0);
        rst = 1'b0;

        // Per-cycle vectors: idle ticks, start, level-held ticks, pause,
        // resume with tick high, clear priority.
        for (int i = 0; i < 21; i++) begin
            tick = vecs[i].tick;
            ss   = vecs[i].ss;
            clr  = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_run_a", i), 32'(bus_a.running), 32'(vecs[i].run));
            check($sformatf("vec%0d_dig_a", i), 32'(dig_a()), 32'(vecs[i].digits));
            check($sformatf("vec%0d_dig_b", i), 32'(dig_b()), 32'(vecs[i].digits));
            @(negedge clk);
        end
        tick = 1'b0;
        ss   = 1'b0;
        clr  = 1'b0;
        @(negedge clk);

        // Ten ticks from idle.
        pulse_ss();
        do_ticks(10);
        check("ten_dig", 32'(dig_a()), 32'h0010);
        check("ten_run", 32'(bus_a.running), 32'd1);

        // Pause sequence ending at 00:07.
        pulse_clr();
        pulse_ss();
        do_ticks(5);
        check("pause_run1", 32'(bus_a.running), 32'd1);
        pulse_ss();
        check("pause_run0", 32'(bus_a.running), 32'd0);
        do_ticks(4);
        check("pause_dig5", 32'(dig_a()), 32'h0005);
        pulse_ss();
        check("pause_run1b", 32'(bus_a.running), 32'd1);
        do_ticks(2);
        check("pause_dig7", 32'(dig_a()), 32'h0007);

        // Full range count with carry checks.
        pulse_clr();
        pulse_ss();
        do_ticks(599);
        check("carry_0959", 32'(dig_a()), 32'h0959);
        do_tick();
        check("carry_1000", 32'(dig_a()), 32'h1000);
        do_ticks(2999);
        check("max_a", 32'(dig_a()), 32'h5959);
        check("max_b", 32'(dig_b()), 32'h5959);
        check("max_flag_pre", 32'(bus_a.max_reached), 32'd0);

        // Tick 3600.
        tick = 1'b1;
        @(posedge clk);
        #1;
        check("hold_dig_a",  32'(dig_a()), 32'h5959);
        check("hold_max_a",  32'(bus_a.max_reached), 32'd1);
        check("hold_run_a",  32'(bus_a.running), 32'd0);
        check("wrap_dig_b",  32'(dig_b()), 32'h0000);
        check("wrap_pls_b",  32'(bus_b.wrap_pulse), 32'd1);
        check("wrap_run_b",  32'(bus_b.running), 32'd1);
        @(posedge clk);
        #1;
        check("wrap_pls_end", 32'(bus_b.wrap_pulse), 32'd0);
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);

        // Tick 3601.
        do_tick();
        check("wrap_dig_b1", 32'(dig_b()), 32'h0001);
        check("hold_dig_a1", 32'(dig_a()), 32'h5959);

        // start_stop ignored in HOLD, then clear.
        pulse_ss();
        check("hold_ss_max", 32'(bus_a.max_reached), 32'd1);
        check("hold_ss_run", 32'(bus_a.running), 32'd0);
        check("hold_ss_dig", 32'(dig_a()), 32'h5959);
        pulse_clr();
        check("clr_dig_a", 32'(dig_a()), 32'h0000);
        check("clr_max_a", 32'(bus_a.max_reached), 32'd0);
        do_tick();
        check("clr_idle_a", 32'(dig_a()), 32'h0000);

        // Async reset in the middle of a count.
        pulse_ss();
        do_ticks(3);
        tick = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_dig", 32'(dig_a()), 32'h0004);
        rst = 1'b1;
        #1;
        check("rst_dig_a", 32'(dig_a()), 32'h0000);
        check("rst_run_a", 32'(bus_a.running), 32'd0);
        check("rst_dig_b", 32'(dig_b()), 32'h0000);
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        check("post_rst_run", 32'(bus_a.running), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
